// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data-memory controller: CPU (C) and loader (L)
// share one controller port, one transaction at a time, with an optional stuck-memory timeout.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FUNC3_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_read_En,
  input  logic                     c_write_En,
  input  logic [FUNC3_WIDTH-1:0]   c_func3,
  input  logic [ADDRESS_WIDTH-1:0] c_address,
  input  logic [DATA_WIDTH-1:0]    c_data_in,
  output logic [DATA_WIDTH-1:0]    c_data_out,
  output logic                     c_ready,
  input  logic                     l_read_En,
  input  logic                     l_write_En,
  input  logic [FUNC3_WIDTH-1:0]   l_func3,
  input  logic [ADDRESS_WIDTH-1:0] l_address,
  input  logic [DATA_WIDTH-1:0]    l_data_in,
  output logic [DATA_WIDTH-1:0]    l_data_out,
  output logic                     l_ready,
  output logic                     mem_read_En,
  output logic                     mem_write_En,
  output logic [FUNC3_WIDTH-1:0]   mem_func3,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_ready,
  output logic                     grant_l,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     ptr_l_q, ptr_l_d;
  logic                     grant_l_q, grant_l_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic [FUNC3_WIDTH-1:0]   func3_q, func3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     c_ready_q, c_ready_d;
  logic                     l_ready_q, l_ready_d;
  logic [DATA_WIDTH-1:0]    c_data_q, c_data_d;
  logic [DATA_WIDTH-1:0]    l_data_q, l_data_d;
  logic                     terr_q, terr_d;

  logic c_req_s, l_req_s, pick_l_s, sel_wr_s, tmo_hit_s;

  assign c_req_s   = c_read_En | c_write_En;
  assign l_req_s   = l_read_En | l_write_En;
  // Loader wins when it is alone or when both ask and the pointer names it.
  assign pick_l_s  = l_req_s & (~c_req_s | ptr_l_q);
  assign sel_wr_s  = pick_l_s ? l_write_En : c_write_En;
  assign tmo_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_l_q   <= 1'b0;
      grant_l_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      func3_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 32'd0;
      c_ready_q <= 1'b0;
      l_ready_q <= 1'b0;
      c_data_q  <= '0;
      l_data_q  <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_l_q   <= ptr_l_d;
      grant_l_q <= grant_l_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      func3_q   <= func3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      c_ready_q <= c_ready_d;
      l_ready_q <= l_ready_d;
      c_data_q  <= c_data_d;
      l_data_q  <= l_data_d;
      terr_q    <= terr_d;
    end
  end

  // Next-state and output logic; ready pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    ptr_l_d   = ptr_l_q;
    grant_l_d = grant_l_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    func3_d   = func3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    c_ready_d = 1'b0;
    l_ready_d = 1'b0;
    c_data_d  = c_data_q;
    l_data_d  = l_data_q;
    terr_d    = terr_q;
    case (state_q)
      S_IDLE: begin
        if (c_req_s || l_req_s) begin
          state_d   = S_BUSY;
          grant_l_d = pick_l_s;
          wr_d      = sel_wr_s;
          rd_d      = ~sel_wr_s;
          func3_d   = pick_l_s ? l_func3   : c_func3;
          addr_d    = pick_l_s ? l_address : c_address;
          wdata_d   = pick_l_s ? l_data_in : c_data_in;
          cnt_d     = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ready || tmo_hit_s) begin
          state_d   = S_RELEASE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          ptr_l_d   = ~grant_l_q;
          l_ready_d = grant_l_q;
          c_ready_d = ~grant_l_q;
          // A timeout completes without data; only a real read response is captured.
          terr_d    = terr_q | ~mem_ready;
          if (mem_ready && rd_q) begin
            l_data_d = grant_l_q ? mem_data_out : l_data_q;
            c_data_d = grant_l_q ? c_data_q : mem_data_out;
          end else begin
            l_data_d = l_data_q;
            c_data_d = c_data_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RELEASE: begin
        state_d   = S_IDLE;
        grant_l_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        grant_l_d = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
      end
    endcase
  end

  assign mem_read_En  = rd_q;
  assign mem_write_En = wr_q;
  assign mem_func3    = func3_q;
  assign mem_address  = addr_q;
  assign mem_data_in  = wdata_q;
  assign c_ready      = c_ready_q;
  assign l_ready      = l_ready_q;
  assign c_data_out   = c_data_q;
  assign l_data_out   = l_data_q;
  assign grant_l      = grant_l_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected memory requests and ready responses are queued by
// the stimulus, and an independent monitor pops and compares them as the DUT presents them.
module tb_dmem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk, rst;
  logic        c_read_En, c_write_En, l_read_En, l_write_En;
  logic [2:0]  c_func3, l_func3, mem_func3;
  logic [31:0] c_address, c_data_in, c_data_out, l_address, l_data_in, l_data_out;
  logic        c_ready, l_ready, mem_read_En, mem_write_En, mem_ready, grant_l, timeout_err;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  typedef struct packed {logic port; logic [31:0] data;} rsp_t;
  typedef struct packed {logic port; logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;} req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  int   tests = 0;
  int   fails = 0;

  int          mem_lat;
  bit          mem_hang;
  bit          mem_fixed;
  logic [31:0] mem_fixed_data;

  dmem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .c_read_En(c_read_En), .c_write_En(c_write_En), .c_func3(c_func3), .c_address(c_address),
    .c_data_in(c_data_in), .c_data_out(c_data_out), .c_ready(c_ready),
    .l_read_En(l_read_En), .l_write_En(l_write_En), .l_func3(l_func3), .l_address(l_address),
    .l_data_in(l_data_in), .l_data_out(l_data_out), .l_ready(l_ready),
    .mem_read_En(mem_read_En), .mem_write_En(mem_write_En), .mem_func3(mem_func3),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .grant_l(grant_l), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: raises mem_ready in the mem_lat-th cycle of a request unless hung.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_data_out = 32'h0;
    forever begin
      @(negedge clk);
      if ((mem_read_En || mem_write_En) && !mem_hang) begin
        cnt++;
        if (cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_data_out = mem_fixed ? mem_fixed_data : (mem_address ^ K);
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: compares every new memory request and every ready pulse against the queues.
  initial begin
    logic prev_en, en;
    rsp_t r;
    req_t q;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (c_ready || l_ready) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready: got c_ready=%0b l_ready=%0b, required no pulse", c_ready, l_ready);
        end else begin
          r = rsp_q.pop_front();
          check("ready_port", {30'd0, c_ready, l_ready}, r.port ? 32'd1 : 32'd2);
          check("data_out", r.port ? l_data_out : c_data_out, r.data);
        end
      end
      en = mem_read_En | mem_write_En;
      if (en && !prev_en) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem_req: got addr 0x%08h, required no request", mem_address);
        end else begin
          q = req_q.pop_front();
          check("mem_op_rd_wr", {30'd0, mem_read_En, mem_write_En}, q.wr ? 32'd1 : 32'd2);
          check("mem_address", mem_address, q.addr);
          check("mem_func3", {29'd0, mem_func3}, {29'd0, q.f3});
          if (q.wr) check("mem_data_in", mem_data_in, q.wdata);
          check("grant_l", {31'd0, grant_l}, {31'd0, q.port});
        end
      end
      prev_en = en;
    end
  end

  task automatic txn(input bit port, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    int n;
    if (port) begin
      l_read_En = rd; l_write_En = wr; l_func3 = f3; l_address = a; l_data_in = d;
    end else begin
      c_read_En = rd; c_write_En = wr; c_func3 = f3; c_address = a; c_data_in = d;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(port ? l_ready : c_ready) && n < 40);
    check(port ? "l_txn_done" : "c_txn_done", {31'd0, port ? l_ready : c_ready}, 32'd1);
    if (port) begin
      l_read_En = 1'b0; l_write_En = 1'b0;
    end else begin
      c_read_En = 1'b0; c_write_En = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n, hi;
    rst = 1'b1;
    c_read_En = 0; c_write_En = 0; c_func3 = 0; c_address = 0; c_data_in = 0;
    l_read_En = 0; l_write_En = 0; l_func3 = 0; l_address = 0; l_data_in = 0;
    mem_lat = 2; mem_hang = 0; mem_fixed = 0; mem_fixed_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mem_rd", {31'd0, mem_read_En}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_write_En}, 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_ready", {30'd0, c_ready, l_ready}, 32'd0);
    check("rst_c_data", c_data_out, 32'd0);
    check("rst_l_data", l_data_out, 32'd0);
    check("rst_grant_l", {31'd0, grant_l}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);

    // CPU read alone, 1-cycle grant latency, memory ready in the third BUSY cycle
    mem_lat = 3; mem_fixed = 1; mem_fixed_data = 32'hDEAD_BEEF;
    req_q.push_back(req_t'{1'b0, 1'b0, 3'd2, 32'h10, 32'h0});
    rsp_q.push_back(rsp_t'{1'b0, 32'hDEAD_BEEF});
    c_read_En = 1; c_func3 = 3'd2; c_address = 32'h10; c_data_in = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("t1_rd_en_cyc%0d", k), {31'd0, mem_read_En}, (k <= 3) ? 32'd1 : 32'd0);
      check($sformatf("t1_c_ready_cyc%0d", k), {31'd0, c_ready}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("t1_grant_l", {31'd0, grant_l}, 32'd0);
    c_read_En = 0;
    @(posedge clk); #1;
    check("t1_c_data_hold", c_data_out, 32'hDEAD_BEEF);
    mem_fixed = 0; mem_lat = 2;

    // Simultaneous writes after reset: CPU then loader
    do_reset();
    req_q.push_back(req_t'{1'b0, 1'b1, 3'd2, 32'h20, 32'h1111_1111});
    req_q.push_back(req_t'{1'b1, 1'b1, 3'd0, 32'h40, 32'h2222_2222});
    rsp_q.push_back(rsp_t'{1'b0, 32'h0});
    rsp_q.push_back(rsp_t'{1'b1, 32'h0});
    fork
      txn(1'b0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h1111_1111);
      txn(1'b1, 1'b0, 1'b1, 3'd0, 32'h40, 32'h2222_2222);
    join

    // Continuous reads from both ports alternate C,L,C,L
    req_q.push_back(req_t'{1'b0, 1'b0, 3'd2, 32'h100, 32'h0});
    req_q.push_back(req_t'{1'b1, 1'b0, 3'd2, 32'h200, 32'h0});
    req_q.push_back(req_t'{1'b0, 1'b0, 3'd2, 32'h104, 32'h0});
    req_q.push_back(req_t'{1'b1, 1'b0, 3'd2, 32'h204, 32'h0});
    rsp_q.push_back(rsp_t'{1'b0, 32'h100 ^ K});
    rsp_q.push_back(rsp_t'{1'b1, 32'h200 ^ K});
    rsp_q.push_back(rsp_t'{1'b0, 32'h104 ^ K});
    rsp_q.push_back(rsp_t'{1'b1, 32'h204 ^ K});
    fork
      begin
        txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
        txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h104, 32'h0);
      end
      begin
        txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0);
        txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h204, 32'h0);
      end
    join

    // Read and write both set: forwarded as write only, data_out unchanged
    req_q.push_back(req_t'{1'b0, 1'b1, 3'd1, 32'h30, 32'h3333_3333});
    rsp_q.push_back(rsp_t'{1'b0, 32'h104 ^ K});
    txn(1'b0, 1'b1, 1'b1, 3'd1, 32'h30, 32'h3333_3333);

    // Stuck memory: timeout after 8 BUSY cycles
    mem_hang = 1;
    req_q.push_back(req_t'{1'b0, 1'b0, 3'd2, 32'h50, 32'h0});
    rsp_q.push_back(rsp_t'{1'b0, 32'h104 ^ K});
    c_read_En = 1; c_func3 = 3'd2; c_address = 32'h50; c_data_in = 32'h0;
    n = 0; hi = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (mem_read_En) hi++;
    end while (!c_ready && n < 30);
    check("t5_busy_cycles", hi, 32'd8);
    check("t5_c_ready", {31'd0, c_ready}, 32'd1);
    check("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
    c_read_En = 0;
    mem_hang = 0;
    @(posedge clk); #1;
    req_q.push_back(req_t'{1'b0, 1'b0, 3'd2, 32'h58, 32'h0});
    rsp_q.push_back(rsp_t'{1'b0, 32'h58 ^ K});
    txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h58, 32'h0);
    check("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset during a loader transaction aborts it silently and restores CPU priority
    mem_hang = 1;
    req_q.push_back(req_t'{1'b1, 1'b0, 3'd4, 32'h80, 32'h0});
    l_read_En = 1; l_func3 = 3'd4; l_address = 32'h80; l_data_in = 32'h0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t6_grant_l_busy", {31'd0, grant_l}, 32'd1);
    rst = 1'b1;
    l_read_En = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_hang = 0;
    check("t6_mem_rd", {31'd0, mem_read_En}, 32'd0);
    check("t6_mem_wr", {31'd0, mem_write_En}, 32'd0);
    check("t6_l_ready", {31'd0, l_ready}, 32'd0);
    check("t6_grant_l", {31'd0, grant_l}, 32'd0);
    check("t6_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("t6_l_data", l_data_out, 32'd0);
    req_q.push_back(req_t'{1'b0, 1'b1, 3'd2, 32'h60, 32'h6666_6666});
    req_q.push_back(req_t'{1'b1, 1'b1, 3'd2, 32'h70, 32'h7777_7777});
    rsp_q.push_back(rsp_t'{1'b0, 32'h0});
    rsp_q.push_back(rsp_t'{1'b1, 32'h0});
    fork
      txn(1'b0, 1'b0, 1'b1, 3'd2, 32'h60, 32'h6666_6666);
      txn(1'b1, 1'b0, 1'b1, 3'd2, 32'h70, 32'h7777_7777);
    join

    repeat (4) @(posedge clk);
    #1;
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("req_queue_drained", req_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
